// File: rtl/matrix_decompiler.sv
// rtl/matrix_decompiler.sv - RMII frame receiver that unpacks a row-major matrix into addressed elements
module matrix_decompiler #(
    parameter int MAX_ELEMENT_SIZE = 8,
    parameter int MAX_SIZE_A       = 32,
    parameter int MAX_SIZE_B       = 32
) (
    input  logic                          eth_refclk,
    input  logic                          rst,
    input  logic                          crsdv,
    input  logic [1:0]                    dibit,
    output logic [$clog2(MAX_SIZE_A)-1:0] row_addr,
    output logic [$clog2(MAX_SIZE_B)-1:0] col_addr,
    output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
    output logic                          valid_data_out,
    output logic                          frame_done,
    output logic                          frame_error
);

    localparam int AW   = $clog2(MAX_SIZE_A);
    localparam int BW   = $clog2(MAX_SIZE_B);
    localparam int W    = MAX_ELEMENT_SIZE;
    localparam int EDIB = W / 2;
    localparam int DW   = (EDIB > 1) ? $clog2(EDIB) : 1;

    localparam logic [DW-1:0] DLAST = DW'(EDIB - 1);
    localparam logic [8:0]    LIM_A = 9'(MAX_SIZE_A);
    localparam logic [8:0]    LIM_B = 9'(MAX_SIZE_B);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HDR_ROWS,
        HDR_COLS,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t         state;
    logic           blocked;     // set by reset: stay deaf until the wire has gone quiet once
    logic [1:0]     hcnt;
    logic [7:0]     hdr_r;
    logic [7:0]     hdr_c;
    logic [DW-1:0]  dcnt;
    logic [W-1:0]   acc;
    logic [AW-1:0]  row;
    logic [BW-1:0]  col;

    logic [W-1:0]   acc_next;
    logic [7:0]     hdr_c_next;
    logic           last_col;
    logic           last_elem;

    // Next-value helpers: LSB-first dibit shift-in and end-of-row/end-of-matrix detection
    always_comb begin
        acc_next   = (acc >> 2) | (W'(dibit) << (W - 2));
        hdr_c_next = {dibit, hdr_c[7:2]};
        last_col   = (8'(col) == hdr_c);
        last_elem  = last_col && (8'(row) == hdr_r);
    end

    // Receive FSM with registered strobes, indices and element value
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            state          <= IDLE;
            blocked        <= 1'b1;
            hcnt           <= '0;
            hdr_r          <= '0;
            hdr_c          <= '0;
            dcnt           <= '0;
            acc            <= '0;
            row            <= '0;
            col            <= '0;
            row_addr       <= '0;
            col_addr       <= '0;
            matrix_element <= '0;
            valid_data_out <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            valid_data_out <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
            case (state)
                IDLE: begin
                    hcnt <= '0;
                    dcnt <= '0;
                    row  <= '0;
                    col  <= '0;
                    if (!crsdv) begin
                        blocked <= 1'b0;
                    end else if (!blocked && dibit == 2'b01) begin
                        state <= PREAMBLE;
                    end else begin
                        state <= DRAIN;
                    end
                end
                PREAMBLE: begin
                    if (!crsdv) begin
                        state <= IDLE;
                    end else begin
                        case (dibit)
                            2'b01:   state <= PREAMBLE;
                            2'b11: begin
                                state <= HDR_ROWS;
                                hcnt  <= '0;
                            end
                            default: state <= DRAIN;
                        endcase
                    end
                end
                HDR_ROWS: begin
                    if (!crsdv) begin
                        frame_error <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        hdr_r <= {dibit, hdr_r[7:2]};
                        hcnt  <= hcnt + 2'd1;
                        if (hcnt == 2'd3) begin
                            state <= HDR_COLS;
                        end
                    end
                end
                HDR_COLS: begin
                    if (!crsdv) begin
                        frame_error <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        hdr_c <= hdr_c_next;
                        hcnt  <= hcnt + 2'd1;
                        if (hcnt == 2'd3) begin
                            if ({1'b0, hdr_r} >= LIM_A || {1'b0, hdr_c_next} >= LIM_B) begin
                                frame_error <= 1'b1;
                                state       <= DRAIN;
                            end else begin
                                state <= PAYLOAD;
                                dcnt  <= '0;
                                row   <= '0;
                                col   <= '0;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (!crsdv) begin
                        frame_error <= 1'b1;
                        dcnt        <= '0;
                        state       <= IDLE;
                    end else begin
                        acc <= acc_next;
                        if (dcnt == DLAST) begin
                            dcnt           <= '0;
                            valid_data_out <= 1'b1;
                            matrix_element <= acc_next;
                            row_addr       <= row;
                            col_addr       <= col;
                            if (last_elem) begin
                                frame_done <= 1'b1;
                                state      <= DRAIN;
                            end else if (last_col) begin
                                col <= '0;
                                row <= row + AW'(1);
                            end else begin
                                col <= col + BW'(1);
                            end
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!crsdv) begin
                        blocked <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_decompiler.md
MATRIX_DECOMPILER -- requirements
Module: matrix_decompiler

Interface
REQ-001 Parameter MAX_ELEMENT_SIZE, default 8: element width in bits; SHALL be an even number.
REQ-002 Parameter MAX_SIZE_A, default 32: maximum row count.
REQ-003 Parameter MAX_SIZE_B, default 32: maximum column count.
REQ-004 Port eth_refclk  input  1: 50 MHz RMII reference clock; sole clock for all logic.
REQ-005 Port rst  input  1: reset, synchronous to eth_refclk, active-high.
REQ-006 Port crsdv  input  1: RMII carrier-sense/data-valid; high while a frame is on the wire.
REQ-007 Port dibit  input  2: RMII receive data, sampled on every rising eth_refclk edge.
REQ-008 Port row_addr  output  $clog2(MAX_SIZE_A): row index of the current element.
REQ-009 Port col_addr  output  $clog2(MAX_SIZE_B): column index of the current element.
REQ-010 Port matrix_element  output  MAX_ELEMENT_SIZE: reassembled element value.
REQ-011 Port valid_data_out  output  1: single-cycle strobe; row_addr, col_addr and matrix_element are valid while it is high.
REQ-012 Port frame_done  output  1: single-cycle strobe, high in the same cycle as valid_data_out for the last element of the frame.
REQ-013 Port frame_error  output  1: single-cycle strobe marking an aborted frame.

Function
REQ-014 Frame format on the wire: preamble of dibit 2'b01 repeated, then SFD dibit 2'b11, then header byte R (rows-1), then header byte C (cols-1), then (R+1)*(C+1) elements in row-major order.
REQ-015 Every byte and element SHALL be assembled LSB-dibit first: the first dibit received lands in bits [1:0].
REQ-016 Each element SHALL occupy MAX_ELEMENT_SIZE/2 dibits.
REQ-017 FSM states: IDLE, PREAMBLE, HDR_ROWS, HDR_COLS, PAYLOAD, DRAIN.
REQ-018 IDLE: when crsdv=1 and dibit=01, go to PREAMBLE; on any other dibit with crsdv=1, go to DRAIN.
REQ-019 PREAMBLE: dibit 01 stays in PREAMBLE; dibit 11 goes to HDR_ROWS; 00 or 10 goes to DRAIN with no error.
REQ-020 HDR_ROWS/HDR_COLS: collect 4 dibits each into R and C.
REQ-021 If R >= MAX_SIZE_A or C >= MAX_SIZE_B, the block SHALL pulse frame_error on the cycle after the last header dibit, then go to DRAIN.
REQ-022 PAYLOAD: a dibit counter accumulates each element; row/col counters start at 0; col increments per element and wraps to 0 after C, at which point row increments.
REQ-023 Latency: valid_data_out SHALL assert exactly 1 cycle after the final dibit of an element is sampled, with the indices of that element.
REQ-024 After the element at (R,C) is emitted, frame_done SHALL pulse alongside valid_data_out and the FSM SHALL go to DRAIN.
REQ-025 DRAIN: ignore all dibits; return to IDLE on the first cycle crsdv=0. Trailing bytes after completion SHALL NOT produce strobes or errors.
REQ-026 crsdv=0 in HDR_ROWS, HDR_COLS or PAYLOAD (truncated frame) SHALL pulse frame_error on the next cycle, discard any partial element, and return to IDLE.
REQ-027 crsdv=0 in PREAMBLE SHALL return to IDLE with no error.
REQ-028 At most one of the truncation and range errors SHALL be signalled per frame; frame_done and frame_error SHALL never both be high in the same cycle.
REQ-029 Back-to-back frames: a frame whose preamble begins on the cycle after crsdv falls SHALL be received correctly.

Reset
REQ-030 While rst=1: FSM goes to IDLE and all counters and header registers clear; valid_data_out, frame_done, frame_error, row_addr, col_addr and matrix_element are 0 on the following cycle.
REQ-031 Assertion of rst mid-frame SHALL abandon the frame with no strobe; after release, the block SHALL ignore dibits until crsdv goes low and a new preamble starts.

Verification
REQ-032 2x2 frame: 7x01, 11, R=0x01, C=0x01, elements 0x12,0x34,0x56,0x78 -> four strobes at (0,0)=0x12, (0,1)=0x34, (1,0)=0x56, (1,1)=0x78; frame_done only with 0x78.
REQ-033 Dibit order check: element 0xB4 sent as dibits 00,01,11,10 -> matrix_element=0xB4, one cycle after the 4th dibit.
REQ-034 Header R=0x20 with MAX_SIZE_A=32 -> frame_error pulse, no valid_data_out, return to IDLE after crsdv=0.
REQ-035 1x3 frame with crsdv dropping after 2 dibits of the 2nd element -> one strobe (0,0), then a frame_error pulse, no frame_done.
REQ-036 1x1 frame followed by 3 trailing bytes, then an immediate second 1x1 frame with element 0xAA -> two frame_done pulses, second element 0xAA, no frame_error.
REQ-037 rst asserted in PAYLOAD of a 4x4 frame -> outputs 0 next cycle, no strobes for the remainder of that frame; the next frame decodes correctly.
